ring_counter_16bit: RTL and testbench

16-bit shift-register sequencer with two modes: one-hot ring counter (default) or Johnson (twisted-ring) counter. It provides enable, direction control, parallel load, illegal-state detection with optional auto-correction, a wrap pulse and a decoded position output. It is used as a phase/slot generator, e.g. to drive 16 time-slot strobes from one clock.

---
 rtl/ring_counter_16bit.sv | 85 ++++++++
 tb/tb_ring_counter_16bit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ring_counter_16bit.sv
// One-hot ring / Johnson shift sequencer with load, legality check, auto-correct, wrap pulse and decoded position.
// Latency: one clock per step, with out and wrap registered. No backpressure; en gates each step.
module ring_counter_16bit #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RING_SEED    = WIDTH'(1),
  parameter bit               AUTO_CORRECT = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          dir,
  input  logic                          mode,
  input  logic                          load,
  input  logic [WIDTH-1:0]              load_val,
  output logic [WIDTH-1:0]              out,
  output logic                          wrap,
  output logic                          err,
  output logic [$clog2(2*WIDTH)-1:0]    pos
);

  localparam int PW = $clog2(2*WIDTH);

  logic             mode_q;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] new_seed;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] inv;
  logic             lo_ones;
  logic             hi_ones;
  int               ones;

  assign seed     = mode_q ? '0 : RING_SEED;
  assign new_seed = mode   ? '0 : RING_SEED;

  always_comb begin
    nxt = out;
    if (mode_q)
      nxt = dir ? {~out[0], out[WIDTH-1:1]} : {out[WIDTH-2:0], ~out[WIDTH-1]};
    else
      nxt = dir ? {out[0], out[WIDTH-1:1]} : {out[WIDTH-2:0], out[WIDTH-1]};
  end

  // A value of the form 2^k-1 has no bit shared with its successor.
  assign inv     = ~out;
  assign lo_ones = ((out & (out + WIDTH'(1))) == '0);
  assign hi_ones = ((inv & (inv + WIDTH'(1))) == '0);
  assign err     = mode_q ? !(lo_ones || hi_ones) : !$onehot(out);
  assign ones    = $countones(out);

  always_comb begin
    pos = '0;
    if (!err) begin
      if (!mode_q) begin
        for (int i = 0; i < WIDTH; i++)
          if (out[i]) pos = PW'(i);
      end else if (out[0] || (out == '0)) begin
        pos = PW'(ones);
      end else begin
        pos = PW'(2*WIDTH - ones);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out    <= new_seed;
      mode_q <= mode;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        out <= load_val;
      end else if (mode != mode_q) begin
        out    <= new_seed;
        mode_q <= mode;
      end else if (AUTO_CORRECT && err && en) begin
        out <= seed;
      end else if (en) begin
        out  <= nxt;
        wrap <= (nxt == seed);
      end
    end
  end

endmodule

// File: tb/tb_ring_counter_16bit.sv
// Directed bench for ring_counter_16bit; a second instance without auto-correct shares the stimulus.
module tb_ring_counter_16bit;

  logic        clk = 1'b0;
  logic        reset, en, dir, mode, load;
  logic [15:0] load_val;
  logic [15:0] out, out_nc;
  logic        wrap, wrap_nc, err, err_nc;
  logic [4:0]  pos, pos_nc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ring_counter_16bit dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .out(out), .wrap(wrap), .err(err), .pos(pos)
  );

  ring_counter_16bit #(.AUTO_CORRECT(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .out(out_nc), .wrap(wrap_nc), .err(err_nc), .pos(pos_nc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m);
    mode  = m;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
    step();
    step();
    checks++; if (out !== 16'h0001) begin errors++; $display("FAIL reset_out got=%h exp=0001", out); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    checks++; if (err !== 1'b0 || pos !== 5'd0) begin errors++; $display("FAIL reset_err_pos got=%b/%0d exp=0/0", err, pos); end
    reset = 1'b1;
  endtask

  task automatic test_ring_left();
    logic [15:0] e;
    en = 1'b1; dir = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      e = 16'h0001 << (i % 16);
      checks++; if (out !== e) begin errors++; $display("FAIL ring_left_out step=%0d got=%h exp=%h", i, out, e); end
      checks++; if (pos !== 5'(i % 16)) begin errors++; $display("FAIL ring_left_pos step=%0d got=%0d exp=%0d", i, pos, i % 16); end
      checks++; if (wrap !== (i == 16)) begin errors++; $display("FAIL ring_left_wrap step=%0d got=%b exp=%b", i, wrap, i == 16); end
    end
  endtask

  task automatic test_right_hold();
    dir = 1'b1; en = 1'b1;
    step();
    checks++; if (out !== 16'h8000 || pos !== 5'd15) begin errors++; $display("FAIL right_1 got=%h/%0d exp=8000/15", out, pos); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL right_1_wrap got=%b exp=0", wrap); end
    step();
    checks++; if (out !== 16'h4000) begin errors++; $display("FAIL right_2 got=%h exp=4000", out); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out !== 16'h4000 || wrap !== 1'b0) begin errors++; $display("FAIL hold cyc=%0d got=%h/%b exp=4000/0", i, out, wrap); end
    end
    dir = 1'b0;
  endtask

  task automatic test_johnson();
    logic [31:0] e;
    en = 1'b0; dir = 1'b0;
    do_reset(1'b1);
    checks++; if (out !== 16'h0000 || pos !== 5'd0 || err !== 1'b0) begin errors++; $display("FAIL johnson_reset got=%h/%0d/%b exp=0000/0/0", out, pos, err); end
    en = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i <= 16) e = (32'h1 << i) - 32'h1;
      else         e = ~((32'h1 << (i - 16)) - 32'h1) & 32'h0000_FFFF;
      checks++; if (out !== e[15:0]) begin errors++; $display("FAIL johnson_out step=%0d got=%h exp=%h", i, out, e[15:0]); end
      checks++; if (pos !== 5'(i % 32) || err !== 1'b0) begin errors++; $display("FAIL johnson_pos step=%0d got=%0d/%b exp=%0d/0", i, pos, err, i % 32); end
      checks++; if (wrap !== (i == 32)) begin errors++; $display("FAIL johnson_wrap step=%0d got=%b exp=%b", i, wrap, i == 32); end
    end
    en = 1'b0;
  endtask

  task automatic test_load_correct();
    en = 1'b0;
    do_reset(1'b0);
    load = 1'b1; load_val = 16'h0003;
    step();
    load = 1'b0;
    checks++; if (out !== 16'h0003 || out_nc !== 16'h0003) begin errors++; $display("FAIL load_val got=%h/%h exp=0003", out, out_nc); end
    checks++; if (err !== 1'b1 || pos !== 5'd0) begin errors++; $display("FAIL load_err got=%b/%0d exp=1/0", err, pos); end
    en = 1'b1;
    step();
    checks++; if (out !== 16'h0001 || wrap !== 1'b0) begin errors++; $display("FAIL autocorrect got=%h/%b exp=0001/0", out, wrap); end
    checks++; if (out_nc !== 16'h0006) begin errors++; $display("FAIL no_correct got=%h exp=0006", out_nc); end
    checks++; if (err !== 1'b0 || pos !== 5'd0) begin errors++; $display("FAIL corrected_err got=%b/%0d exp=0/0", err, pos); end
    en = 1'b0;
  endtask

  task automatic test_mode_switch();
    do_reset(1'b0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (out !== 16'h0010 || pos !== 5'd4) begin errors++; $display("FAIL pre_switch got=%h/%0d exp=0010/4", out, pos); end
    en = 1'b0; mode = 1'b1;
    step();
    checks++; if (out !== 16'h0000 || wrap !== 1'b0) begin errors++; $display("FAIL mode_switch got=%h/%b exp=0000/0", out, wrap); end
    en = 1'b1;
    step();
    checks++; if (out !== 16'h0001) begin errors++; $display("FAIL switch_step1 got=%h exp=0001", out); end
    step();
    checks++; if (out !== 16'h0003 || pos !== 5'd2) begin errors++; $display("FAIL switch_step2 got=%h/%0d exp=0003/2", out, pos); end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++; if (out !== 16'h0400) begin errors++; $display("FAIL pre_async got=%h exp=0400", out); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (out !== 16'h0001 || wrap !== 1'b0) begin errors++; $display("FAIL async_reset got=%h/%b exp=0001/0", out, wrap); end
    step();
    reset = 1'b1;
    load = 1'b1; load_val = 16'h1234;
    step();
    load = 1'b0;
    checks++; if (out !== 16'h1234 || wrap !== 1'b0) begin errors++; $display("FAIL load_over_en got=%h/%b exp=1234/0", out, wrap); end
    checks++; if (err !== 1'b1 || pos !== 5'd0) begin errors++; $display("FAIL load_over_en_err got=%b/%0d exp=1/0", err, pos); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ring_left();
    test_right_hold();
    test_johnson();
    test_load_correct();
    test_mode_switch();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
